// File: rtl/py_uart_rx_fifo.sv
// Receive-side buffer behind the UART core: acknowledges each held byte once
// and queues {err, data} in a first-word-fall-through FIFO with overflow count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for rx_valid; capture and push attempt on entry
//   ST_ACK   | read_rx pulse to the UART core (one cycle)
//   ST_DRAIN | wait for rx_valid to fall so the same byte is never re-pushed
module py_uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rxdata,
  input  logic [7:0]    status,
  output logic          read_rx,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_err,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    overflow_cnt,
  input  logic          clear_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [8:0]  mem_q [DEPTH];

  logic push_try;
  logic push_ok;
  logic drop;
  logic pop;
  logic full;

  // Only bit 0 of status carries meaning for a held byte.
  logic unused_status;
  assign unused_status = ^status[7:1];

  // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
  assign full     = count_q[AW];
  assign pop      = out_valid && out_ready;
  assign push_try = (state_q == ST_IDLE) && rx_valid;
  assign push_ok  = push_try && (!full || pop);
  assign drop     = push_try && !push_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rx_valid) state_d = ST_ACK;
      ST_ACK:   state_d = ST_DRAIN;
      ST_DRAIN: if (!rx_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear survives as a count of one.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf)                  ovf_d = drop ? 8'd1 : 8'd0;
    else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= {status[0], rxdata};
  end

  assign read_rx      = (state_q == ST_ACK);
  assign out_valid    = (count_q != '0);
  assign out_err      = mem_q[rd_ptr_q][8];
  assign out_data     = mem_q[rd_ptr_q][7:0];
  assign fifo_count   = count_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_py_uart_rx_fifo.sv
// Randomized bench for py_uart_rx_fifo against a queue-based reference model,
// with directed passes for ordering, full/overflow, hold-high and reset cases.
module tb_py_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic [7:0] status = 8'h00;
  logic       read_rx;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_ready = 1'b0;
  logic [4:0] fifo_count;
  logic [7:0] overflow_cnt;
  logic       clear_ovf = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  py_uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rxdata(rxdata), .status(status),
    .read_rx(read_rx), .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow_cnt(overflow_cnt),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue of {err,data}; the bench marks the edge at
  // which each new byte is captured, and the acknowledge follows one cycle later.
  logic [8:0] q_m[$];
  int         ovf_m = 0;
  bit         exp_ack = 1'b0;
  bit         capture_now = 1'b0;
  bit         chk_en = 1'b0;
  bit         rand_mode = 1'b0;

  always @(posedge clk) begin
    bit pop_m, drop_m, full_m;
    logic [8:0] popped;
    if (rst) begin
      q_m.delete();
      ovf_m   = 0;
      exp_ack = 1'b0;
    end else begin
      full_m = (q_m.size() == 16);
      pop_m  = out_ready && (q_m.size() != 0);
      drop_m = 1'b0;
      if (pop_m) popped = q_m.pop_front();
      if (capture_now) begin
        if (!full_m || pop_m) q_m.push_back({status[0], rxdata});
        else drop_m = 1'b1;
      end
      if (clear_ovf) ovf_m = drop_m ? 1 : 0;
      else if (drop_m && ovf_m < 255) ovf_m++;
      exp_ack = capture_now;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_rx", read_rx, exp_ack);
      chk("out_valid", out_valid, q_m.size() != 0);
      chk("fifo_count", fifo_count, q_m.size());
      chk("overflow_cnt", overflow_cnt, ovf_m);
      if (q_m.size() != 0) chk("head", {out_err, out_data}, q_m[0]);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) == 0);
      clear_ovf = ($urandom_range(0, 40) == 0);
    end
  endtask

  // UART core model: hold the byte, drop rx_valid after read_rx (plus extra
  // hold cycles), then leave enough idle time for the FSM to return to IDLE.
  task automatic send(input logic [7:0] d, input bit e, input int hold,
                      input bit pop_cap, input bit clr_cap);
    rx_valid    = 1'b1;
    rxdata      = d;
    status      = {7'($urandom), e};
    capture_now = 1'b1;
    if (pop_cap) out_ready = 1'b1;
    if (clr_cap) clear_ovf = 1'b1;
    tick();
    capture_now = 1'b0;
    if (pop_cap) out_ready = 1'b0;
    if (clr_cap) clear_ovf = 1'b0;
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    repeat (18) tick();
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_order [16];
    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_ovf", overflow_cnt, 8'd0);
    chk("rst_read_rx", read_rx, 1'b0);

    send(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    chk("single_data", out_data, 8'hA5);
    chk("single_err", out_err, 1'b0);
    chk("single_count", fifo_count, 5'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("single_pop", fifo_count, 5'd0);

    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0, 1'b0, 1'b0);
    chk("fill_count", fifo_count, 5'd16);
    chk("fill_ovf", overflow_cnt, 8'd0);

    send(8'h55, 1'b0, 0, 1'b0, 1'b0);
    send(8'h66, 1'b0, 0, 1'b0, 1'b0);
    chk("drop_ovf", overflow_cnt, 8'd2);
    chk("drop_count", fifo_count, 5'd16);
    chk("drop_head", out_data, 8'h00);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    tick();
    chk("clear_ovf", overflow_cnt, 8'd0);

    send(8'h77, 1'b0, 0, 1'b1, 1'b0);
    chk("full_pop_push_count", fifo_count, 5'd16);
    for (int i = 0; i < 15; i++) exp_order[i] = 8'(i + 1);
    exp_order[15] = 8'h77;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", out_data, exp_order[i]);
      tick();
    end
    out_ready = 1'b0;
    tick();
    chk("drain_empty", fifo_count, 5'd0);

    send(8'h42, 1'b0, 10, 1'b0, 1'b0);
    chk("hold_one_push", fifo_count, 5'd1);
    chk("hold_data", out_data, 8'h42);
    drain_all();

    send(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    chk("err_flag", out_err, 1'b1);
    chk("err_data", out_data, 8'h3C);
    drain_all();

    for (int i = 0; i < 16; i++) send(8'($urandom), 1'($urandom), 0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) send(8'($urandom), 1'b0, 0, 1'b0, 1'b0);
    chk("ovf_saturate", overflow_cnt, 8'd255);
    send(8'h99, 1'b0, 0, 1'b0, 1'b1);
    chk("clear_with_drop", overflow_cnt, 8'd1);

    rx_valid    = 1'b1;
    rxdata      = 8'hE1;
    status      = 8'h00;
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0;
    chk("ack_before_rst", read_rx, 1'b1);
    rst      = 1'b1;
    rx_valid = 1'b0;
    tick();
    chk("rst_ack_read_rx", read_rx, 1'b0);
    chk("rst_ack_valid", out_valid, 1'b0);
    chk("rst_ack_ovf", overflow_cnt, 8'd0);
    rst = 1'b0;
    tick();

    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_mode = 1'b0;
    clear_ovf = 1'b0;
    drain_all();
    chk("final_empty", fifo_count, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
